// File: rtl/latch_bank_if.sv
// rtl/latch_bank_if.sv - per-channel set/reset/gate/data bundle and outputs for latch_bank
//
// Ports (signals):
//   s, r, g   CHANNELS bits, per-channel set, reset and gate / derived clock
//   d         CHANNELS*WIDTH bits, data in, channel i at [WIDTH*(i+1)-1:WIDTH*i]
//   q         CHANNELS*WIDTH bits, data out, same packing
//   chg       CHANNELS bits, registered "stored value changed" pulse
// Modports: master drives s/r/g/d, slave (the bank) drives q/chg.
interface latch_bank_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       s;
  logic [CHANNELS-1:0]       r;
  logic [CHANNELS-1:0]       g;
  logic [CHANNELS*WIDTH-1:0] d;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS-1:0]       chg;

  modport master (output s, r, g, d, input q, chg);
  modport slave  (input s, r, g, d, output q, chg);
endinterface

// File: rtl/latch_bank.sv
// rtl/latch_bank.sv - bank of independent latch / edge-flop emulation cells in one clock domain
//
// Ports:
//   clock   system clock, sole clock domain
//   resb    asynchronous active-low reset
//   bus     latch_bank_if.slave: s/r/g/d in, q (combinational) and chg (registered) out
// Parameters:
//   WIDTH    bits per channel
//   CHANNELS number of channels
//   MODE     2 bits per channel: 0 latch, 1 rising g, 2 falling g, 3 both edges
//   SET_VAL  value forced by s
//   INIT     storage value loaded by reset
module latch_bank #(
  parameter int                    WIDTH    = 1,
  parameter int                    CHANNELS = 4,
  parameter logic [2*CHANNELS-1:0] MODE     = '0,
  parameter logic [WIDTH-1:0]      SET_VAL  = WIDTH'(1),
  parameter logic [WIDTH-1:0]      INIT     = '0
) (
  input  logic         clock,
  input  logic         resb,
  latch_bank_if.slave  bus
);

  logic [WIDTH-1:0]          val_q [CHANNELS];
  logic [WIDTH-1:0]          val_d [CHANNELS];
  logic [CHANNELS-1:0]       gp_q;
  logic [CHANNELS-1:0]       gp_d;
  logic [CHANNELS-1:0]       chg_q;
  logic [CHANNELS-1:0]       chg_d;
  logic [CHANNELS-1:0]       active;
  logic [CHANNELS*WIDTH-1:0] q_all;

  // gp_q holds the gate as sampled at the last clock edge, so comparing it
  // with the live gate yields an edge that is active for exactly the first
  // cycle after the transition. The override (r, then s) wins over an edge,
  // but gp still advances, so the edge is consumed rather than deferred.
  always_comb begin
    active = '0;
    q_all  = '0;
    gp_d   = bus.g;
    chg_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      val_d[i] = val_q[i];
      case (MODE[2*i +: 2])
        2'd0:    active[i] = bus.g[i];
        2'd1:    active[i] = bus.g[i] & ~gp_q[i];
        2'd2:    active[i] = ~bus.g[i] & gp_q[i];
        default: active[i] = bus.g[i] ^ gp_q[i];
      endcase
      if (bus.r[i]) begin
        val_d[i] = '0;
      end else if (bus.s[i]) begin
        val_d[i] = SET_VAL;
      end else if (active[i]) begin
        val_d[i] = bus.d[WIDTH*i +: WIDTH];
      end
      q_all[WIDTH*i +: WIDTH] = val_d[i];
      chg_d[i] = (val_d[i] != val_q[i]);
    end
  end

  always_ff @(posedge clock or negedge resb) begin
    if (!resb) begin
      for (int i = 0; i < CHANNELS; i++) begin
        val_q[i] <= INIT;
      end
      gp_q  <= '0;
      chg_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        val_q[i] <= val_d[i];
      end
      gp_q  <= gp_d;
      chg_q <= chg_d;
    end
  end

  assign bus.q   = q_all;
  assign bus.chg = chg_q;

endmodule

// File: tb/tb_latch_bank.sv
// tb/tb_latch_bank.sv - scoreboard bench for latch_bank with directed and random stimulus
module tb_latch_bank;
  localparam int              W     = 4;
  localparam int              C     = 4;
  localparam logic [2*C-1:0]  MODEP = 8'b11_10_01_00;
  localparam logic [W-1:0]    SETV  = 4'd1;
  localparam logic [W-1:0]    INITV = 4'd0;

  logic clock = 1'b0;
  logic resb;
  always #5 clock = ~clock;

  latch_bank_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  latch_bank #(
    .WIDTH(W), .CHANNELS(C), .MODE(MODEP), .SET_VAL(SETV), .INIT(INITV)
  ) dut (
    .clock(clock),
    .resb(resb),
    .bus(bus)
  );

  typedef struct {
    int              cyc;
    logic [C*W-1:0]  q;
    logic [C*W-1:0]  qm;
    logic [C-1:0]    chg;
    logic [C-1:0]    cm;
    string           name;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: stored word, gate seen at last clock, change flag.
  logic [W-1:0] m_val [C];
  bit           m_gp  [C];
  bit           m_chg [C];

  function automatic logic [W-1:0] model_q(int ch);
    bit gi, rose, fell, take;
    gi   = bus.g[ch];
    rose = gi && !m_gp[ch];
    fell = !gi && m_gp[ch];
    case (MODEP[2*ch +: 2])
      2'd0:    take = gi;
      2'd1:    take = rose;
      2'd2:    take = fell;
      default: take = rose || fell;
    endcase
    if (bus.r[ch]) return '0;
    if (bus.s[ch]) return SETV;
    if (take) return bus.d[W*ch +: W];
    return m_val[ch];
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < C; ch++) begin
      m_val[ch] = INITV;
      m_gp[ch]  = 1'b0;
      m_chg[ch] = 1'b0;
    end
  endtask

  task automatic apply(input logic [C-1:0] s_, input logic [C-1:0] r_,
                       input logic [C-1:0] g_, input logic [C*W-1:0] d_, input bit rb);
    logic [W-1:0] nq [C];
    exp_t e;
    @(posedge clock);
    #1;
    cycle++;
    if (resb) begin
      for (int ch = 0; ch < C; ch++) nq[ch] = model_q(ch);
      for (int ch = 0; ch < C; ch++) begin
        m_chg[ch] = (nq[ch] != m_val[ch]);
        m_val[ch] = nq[ch];
        m_gp[ch]  = bus.g[ch];
      end
    end
    bus.s = s_;
    bus.r = r_;
    bus.g = g_;
    bus.d = d_;
    resb  = rb;
    if (!rb) model_reset();
    e.cyc  = cycle;
    e.qm   = '1;
    e.cm   = '1;
    e.name = "model";
    for (int ch = 0; ch < C; ch++) begin
      e.q[W*ch +: W] = model_q(ch);
      e.chg[ch]      = m_chg[ch];
    end
    sb.push_back(e);
  endtask

  task automatic one(input int ch, input bit s_, input bit r_, input bit g_,
                     input logic [W-1:0] d_, input bit rb);
    logic [C-1:0]   m;
    logic [C*W-1:0] dv;
    m  = C'(1) << ch;
    dv = {{(C*W-W){1'b0}}, d_} << (W*ch);
    apply(s_ ? m : '0, r_ ? m : '0, g_ ? m : '0, dv, rb);
  endtask

  // Fixed expectation for one channel in the current cycle.
  task automatic chk(input int ch, input logic [W-1:0] qv, input bit cv, input string nm);
    exp_t e;
    e.cyc  = cycle;
    e.q    = {{(C*W-W){1'b0}}, qv} << (W*ch);
    e.qm   = {{(C*W-W){1'b0}}, {W{1'b1}}} << (W*ch);
    e.chg  = C'(cv) << ch;
    e.cm   = C'(1) << ch;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation for this cycle at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
        e = sb.pop_front();
        n_vec++;
        if ((((bus.q ^ e.q) & e.qm) !== '0) || (((bus.chg ^ e.chg) & e.cm) !== '0)) begin
          n_err++;
          $display("FAIL %s cyc=%0d q=%h chg=%b expected q=%h chg=%b (mask q=%h chg=%b)",
                   e.name, e.cyc, bus.q, bus.chg, e.q, e.chg, e.qm, e.cm);
        end
      end
    end
  end

  logic [5:0] gseq;
  logic [W-1:0] m3_q [6];
  bit           m3_c [6];

  initial begin
    resb  = 1'b0;
    bus.s = '0;
    bus.r = '0;
    bus.g = '0;
    bus.d = '0;
    model_reset();

    apply('0, '0, '0, '0, 1'b0);
    apply('0, '0, '0, '0, 1'b0);
    for (int ch = 0; ch < C; ch++) chk(ch, INITV, 1'b0, "reset");
    one(0, 0, 0, 0, 4'h0, 1);

    // mode 0 transparent latch on channel 0
    one(0, 0, 0, 1, 4'h5, 1); chk(0, 4'h5, 1'b0, "m0_transparent");
    one(0, 0, 0, 0, 4'h9, 1); chk(0, 4'h5, 1'b1, "m0_hold_chg");
    one(0, 0, 0, 0, 4'h9, 1); chk(0, 4'h5, 1'b0, "m0_no_repeat_chg");

    // mode 1 rising edge on channel 1
    one(1, 0, 0, 0, 4'h3, 1); chk(1, 4'h0, 1'b0, "m1_idle");
    one(1, 0, 0, 1, 4'h3, 1); chk(1, 4'h3, 1'b0, "m1_edge");
    one(1, 0, 0, 1, 4'h7, 1); chk(1, 4'h3, 1'b1, "m1_held_high");
    one(1, 0, 0, 1, 4'h7, 1); chk(1, 4'h3, 1'b0, "m1_held_high2");
    one(1, 0, 0, 0, 4'h7, 1); chk(1, 4'h3, 1'b0, "m1_fall_no_capture");
    one(1, 0, 0, 0, 4'h7, 1); chk(1, 4'h3, 1'b0, "m1_after_fall");

    // mode 2 and mode 3 with g = 0,1,1,0,0,1 and d = step index
    gseq = 6'b100110;
    for (int k = 0; k < 6; k++) begin
      one(2, 0, 0, gseq[k], W'(k), 1);
      chk(2, (k >= 3) ? 4'h3 : 4'h0, (k == 4), "m2_fall");
    end
    m3_q[0] = 4'h0; m3_q[1] = 4'h1; m3_q[2] = 4'h1;
    m3_q[3] = 4'h3; m3_q[4] = 4'h3; m3_q[5] = 4'h5;
    m3_c[0] = 0; m3_c[1] = 0; m3_c[2] = 1; m3_c[3] = 0; m3_c[4] = 1; m3_c[5] = 0;
    for (int k = 0; k < 6; k++) begin
      one(3, 0, 0, gseq[k], W'(k), 1);
      chk(3, m3_q[k], m3_c[k], "m3_both");
    end
    one(3, 0, 0, 1, 4'h0, 1); chk(3, 4'h5, 1'b1, "m3_stored");

    // priority on channel 0 (holding 5)
    one(0, 1, 1, 1, 4'hF, 1); chk(0, 4'h0, 1'b0, "prio_r_wins");
    one(0, 1, 0, 1, 4'hF, 1); chk(0, SETV, 1'b1, "prio_s");
    one(0, 0, 0, 0, 4'hF, 1); chk(0, 4'h1, 1'b1, "prio_hold");
    one(0, 0, 0, 0, 4'hF, 1); chk(0, 4'h1, 1'b0, "prio_settled");

    // asynchronous reset mid-operation, then release with g high in mode 1
    one(0, 0, 0, 1, 4'hA, 1);
    one(0, 0, 0, 0, 4'h0, 1); chk(0, 4'hA, 1'b1, "pre_reset");
    one(0, 0, 0, 0, 4'h0, 0); chk(0, INITV, 1'b0, "reset_async");
    one(1, 0, 0, 1, 4'h6, 0); chk(0, INITV, 1'b0, "reset_held");
    one(1, 0, 0, 1, 4'h6, 1); chk(1, 4'h6, 1'b0, "release_edge");
    one(1, 0, 0, 1, 4'h8, 1); chk(1, 4'h6, 1'b1, "release_captured");

    // random mixed-mode traffic
    for (int n = 0; n < 10000; n++) begin
      apply(C'($urandom & $urandom & $urandom & $urandom),
            C'($urandom & $urandom & $urandom & $urandom),
            C'($urandom),
            (C*W)'($urandom),
            ($urandom_range(0, 299) != 0));
    end

    repeat (2) @(posedge clock);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
